// File: rtl/ddr3_app_bridge.sv
`default_nettype none
//==============================================================================
// Module      : ddr3_app_bridge
// Description : Upstream request stage in front of the app-side command/data
//               interface of a DDR3 memory controller IP. Handles one
//               single-beat read or write at a time. The command goes out on
//               cmd/cmd_en and the write beat on wr_data_en/wr_data_end.
//               Read data is captured on rd_data_valid, with a timeout. Each
//               request gets exactly one response on a valid/ready port.
//               All traffic is held off until init_calib_complete.
//
//               Optional build macro: DDR3_BRIDGE_STAT_EN
//                 Adds stat_wr_cnt[31:0], stat_rd_cnt[31:0] and
//                 stat_to_cnt[15:0] completion/timeout counters.
//
// Ports:
//   clk, rst               clk_out of the IP; asynchronous active-high reset
//   req_*                  request port (valid/ready, we, addr, wdata, wmask)
//   rsp_*                  response port (valid/ready, we echo, rdata, err)
//   init_calib_complete    calibration done flag from the IP
//   app_burst_number       tied to 0
//   cmd, cmd_en, cmd_ready, app_addr
//                          command channel (cmd 0 = write, 1 = read)
//   wr_data*, wr_data_rdy  write data channel (single beat)
//   rd_data*               read return channel
//   stat_*                 statistics (DDR3_BRIDGE_STAT_EN only)
//
// Revision    : 1.0 - initial release
//==============================================================================
module ddr3_app_bridge #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // request port
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    // response port
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_we,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
`ifdef DDR3_BRIDGE_STAT_EN
    // statistics
    output logic [31:0]         stat_wr_cnt,
    output logic [31:0]         stat_rd_cnt,
    output logic [15:0]         stat_to_cnt,
`endif
    // DDR3 IP app interface
    input  logic                init_calib_complete,
    output logic [5:0]          app_burst_number,
    output logic [2:0]          cmd,
    output logic                cmd_en,
    input  logic                cmd_ready,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_data_en,
    output logic                wr_data_end,
    output logic [DATA_W/8-1:0] wr_data_mask,
    input  logic                wr_data_rdy,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_data_valid,
    input  logic                rd_data_end
);

    localparam int                c_MASK_W  = DATA_W / 8;
    localparam int                c_CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]        c_CMD_WR  = 3'd0;
    localparam logic [2:0]        c_CMD_RD  = 3'd1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WCMD  = 3'd2,
        S_WDAT  = 3'd3,
        S_RCMD  = 3'd4,
        S_RWAIT = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Registered outputs and their next-state values
    logic                  r_req_ready,    w_req_ready_nxt;
    logic                  r_rsp_valid,    w_rsp_valid_nxt;
    logic                  r_rsp_we,       w_rsp_we_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata,    w_rsp_rdata_nxt;
    logic                  r_rsp_err,      w_rsp_err_nxt;
    logic [2:0]            r_cmd,          w_cmd_nxt;
    logic [ADDR_W-1:0]     r_app_addr,     w_app_addr_nxt;
    logic [DATA_W-1:0]     r_wr_data,      w_wr_data_nxt;
    logic [c_MASK_W-1:0]   r_wr_data_mask, w_wr_data_mask_nxt;

    logic [c_CNT_W-1:0]    r_to_cnt;
    logic                  w_to_hit;
    logic                  w_req_fire;
    logic                  w_rsp_fire;
    logic                  w_cmd_fire;
    logic                  w_wr_fire;

    // rd_data_end always accompanies rd_data_valid on a single-beat read,
    // so it carries no extra information here.
    logic                  w_unused;
    assign w_unused = rd_data_end;

    //--------------------------------------------------------------------------
    // Handshake strobes. Command and write-data strobes are combinational so
    // they are high exactly in the cycle the IP reports ready.
    //--------------------------------------------------------------------------
    assign w_req_fire = (r_state == S_IDLE) && r_req_ready && req_valid;
    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;
    assign w_cmd_fire = ((r_state == S_WCMD) || (r_state == S_RCMD)) && cmd_ready;
    assign w_wr_fire  = (r_state == S_WDAT) && wr_data_rdy;
    assign w_to_hit   = (r_to_cnt == c_TO_LAST);

    assign cmd_en           = w_cmd_fire;
    assign wr_data_en       = w_wr_fire;
    assign wr_data_end      = w_wr_fire;
    assign app_burst_number = 6'd0;

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_we       = r_rsp_we;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign cmd          = r_cmd;
    assign app_addr     = r_app_addr;
    assign wr_data      = r_wr_data;
    assign wr_data_mask = r_wr_data_mask;

    //--------------------------------------------------------------------------
    // State register and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_INIT;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_we       <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            r_cmd          <= c_CMD_WR;
            r_app_addr     <= '0;
            r_wr_data      <= '0;
            r_wr_data_mask <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_req_ready    <= w_req_ready_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_we       <= w_rsp_we_nxt;
            r_rsp_rdata    <= w_rsp_rdata_nxt;
            r_rsp_err      <= w_rsp_err_nxt;
            r_cmd          <= w_cmd_nxt;
            r_app_addr     <= w_app_addr_nxt;
            r_wr_data      <= w_wr_data_nxt;
            r_wr_data_mask <= w_wr_data_mask_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and next-output logic. Every register holds by default.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_req_ready_nxt    = r_req_ready;
        w_rsp_valid_nxt    = r_rsp_valid;
        w_rsp_we_nxt       = r_rsp_we;
        w_rsp_rdata_nxt    = r_rsp_rdata;
        w_rsp_err_nxt      = r_rsp_err;
        w_cmd_nxt          = r_cmd;
        w_app_addr_nxt     = r_app_addr;
        w_wr_data_nxt      = r_wr_data;
        w_wr_data_mask_nxt = r_wr_data_mask;

        case (r_state)
            S_INIT: begin
                // Calibration is only looked at here. Losing it later is
                // not our concern.
                if (init_calib_complete) begin
                    w_state_nxt     = S_IDLE;
                    w_req_ready_nxt = 1'b1;
                end
            end

            S_IDLE: begin
                if (w_req_fire) begin
                    w_req_ready_nxt    = 1'b0;
                    w_app_addr_nxt     = req_addr;
                    w_wr_data_nxt      = req_wdata;
                    w_wr_data_mask_nxt = req_wmask;
                    w_cmd_nxt          = req_we ? c_CMD_WR : c_CMD_RD;
                    w_rsp_we_nxt       = req_we;
                    w_state_nxt        = req_we ? S_WCMD : S_RCMD;
                end
            end

            S_WCMD: begin
                if (w_cmd_fire) begin
                    w_state_nxt = S_WDAT;
                end
            end

            S_WDAT: begin
                if (w_wr_fire) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_RESP;
                end
            end

            S_RCMD: begin
                if (w_cmd_fire) begin
                    w_state_nxt = S_RWAIT;
                end
            end

            S_RWAIT: begin
                // Data arriving in the last allowed cycle still counts as
                // a good read, so it is tested before the timeout.
                if (rd_data_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = rd_data;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_RESP;
                end else if (w_to_hit) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end

            S_RESP: begin
                if (w_rsp_fire) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt     = S_INIT;
                w_req_ready_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Read timeout counter. It is zero on the first RWAIT cycle and counts
    // every RWAIT cycle, so TIMEOUT_CYC RWAIT cycles pass before an error.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_RWAIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

`ifdef DDR3_BRIDGE_STAT_EN
    //--------------------------------------------------------------------------
    // Completion statistics, updated on the response handshake. A timed-out
    // read still counts as a completed read.
    //--------------------------------------------------------------------------
    logic [31:0] r_stat_wr_cnt;
    logic [31:0] r_stat_rd_cnt;
    logic [15:0] r_stat_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_wr_cnt <= '0;
            r_stat_rd_cnt <= '0;
            r_stat_to_cnt <= '0;
        end else if (w_rsp_fire) begin
            if (r_rsp_we) begin
                r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
            end else begin
                r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
            end
            if (r_rsp_err && (r_stat_to_cnt != 16'hFFFF)) begin
                r_stat_to_cnt <= r_stat_to_cnt + 16'd1;
            end
        end
    end

    assign stat_wr_cnt = r_stat_wr_cnt;
    assign stat_rd_cnt = r_stat_rd_cnt;
    assign stat_to_cnt = r_stat_to_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr3_app_bridge.sv
`default_nettype none
//==============================================================================
// Module      : tb_ddr3_app_bridge
// Description : Self-checking bench for ddr3_app_bridge. A request driver
//               pushes expected commands and responses into queues. An IP
//               model answers cmd/wr_data/rd_data and checks the commands.
//               A response monitor pops the response queue and compares.
//               Read data and timeout outcome come from a reference memory
//               and a per-request return latency.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ddr3_app_bridge;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_wmask;
    logic          rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          init_calib_complete;
    logic [5:0]    app_burst_number;
    logic [2:0]    cmd;
    logic          cmd_en, cmd_ready;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] wr_data;
    logic          wr_data_en, wr_data_end, wr_data_rdy;
    logic [MW-1:0] wr_data_mask;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid, rd_data_end;
`ifdef DDR3_BRIDGE_STAT_EN
    logic [31:0]   stat_wr_cnt, stat_rd_cnt;
    logic [15:0]   stat_to_cnt;
`endif

    ddr3_app_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef DDR3_BRIDGE_STAT_EN
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_to_cnt(stat_to_cnt),
`endif
        .init_calib_complete(init_calib_complete),
        .app_burst_number(app_burst_number),
        .cmd(cmd), .cmd_en(cmd_en), .cmd_ready(cmd_ready), .app_addr(app_addr),
        .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_data_end(wr_data_end),
        .wr_data_mask(wr_data_mask), .wr_data_rdy(wr_data_rdy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
        int            lat;      // read return latency after cmd_en, 0 = never
    } cmd_t;

    typedef struct {
        logic          we;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;      // expected accept->rsp_valid cycles, -1 = unchecked
        int            acc_cyc;
    } rsp_t;

    cmd_t          cmd_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] mem_ref[logic [AW-1:0]];
    logic [DW-1:0] mem_ip [logic [AW-1:0]];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_cmd    = 0;
    int n_req    = 0;
    int m_wr = 0, m_rd = 0, m_to = 0;

    // IP / sink behaviour knobs
    bit rand_rdy  = 1'b0;
    bit rand_rsp  = 1'b0;
    int stall_cnt = 0;
    int bp_pending = 0;
    int rd_cnt    = 0;
    logic [AW-1:0] rd_addr;
    bit   wpend   = 1'b0;
    cmd_t wcur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Content of a location nobody has written yet.
    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {5'b0, a} ^ 32'h5A5A_A5A5;
        return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000};
    endfunction

    // Mask bit 1 = byte keeps its old value.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < MW; i++) if (!m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : init_pat(a);
    endfunction

    function automatic logic [DW-1:0] ip_get(input logic [AW-1:0] a);
        return mem_ip.exists(a) ? mem_ip[a] : init_pat(a);
    endfunction

    //--------------------------------------------------------------------------
    // Request driver: presents one request, waits (bounded) for acceptance
    // and records what the bridge must do with it.
    //--------------------------------------------------------------------------
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, input int lat, input int exp_lat);
        cmd_t c;
        rsp_t r;
        bit   ok;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            #1;
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("req_accept_timeout", 128'(req_ready), 128'(1));
            req_valid = 1'b0;
            return;
        end
        c.we = we; c.addr = a; c.wdata = d; c.mask = m; c.lat = lat;
        r.we = we; r.lat = exp_lat; r.acc_cyc = cyc;
        if (we) begin
            mem_ref[a] = merge(ref_get(a), d, m);
            r.rdata = '0;
            r.err   = 1'b0;
        end else begin
            // Data must show up within TO cycles of the command.
            r.err   = (lat == 0) || (lat > TO);
            r.rdata = r.err ? '0 : ref_get(a);
        end
        cmd_q.push_back(c);
        rsp_q.push_back(r);
        n_req++;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 2000 && rsp_q.size() != 0; t++) @(negedge clk);
        chk(nm, 128'(rsp_q.size()), 128'(0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"},  128'(req_ready),  '0);
        chk({tag, "_rsp_valid"},  128'(rsp_valid),  '0);
        chk({tag, "_rsp_we"},     128'(rsp_we),     '0);
        chk({tag, "_rsp_rdata"},  128'(rsp_rdata),  '0);
        chk({tag, "_rsp_err"},    128'(rsp_err),    '0);
        chk({tag, "_cmd"},        128'(cmd),        '0);
        chk({tag, "_cmd_en"},     128'(cmd_en),     '0);
        chk({tag, "_app_addr"},   128'(app_addr),   '0);
        chk({tag, "_wr_data"},    128'(wr_data),    '0);
        chk({tag, "_wr_en"},      128'(wr_data_en), '0);
        chk({tag, "_wr_end"},     128'(wr_data_end),'0);
        chk({tag, "_wr_mask"},    128'(wr_data_mask),'0);
        chk({tag, "_burst_num"},  128'(app_burst_number), '0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef DDR3_BRIDGE_STAT_EN
        chk({tag, "_stat_wr"}, 128'(stat_wr_cnt), 128'(m_wr));
        chk({tag, "_stat_rd"}, 128'(stat_rd_cnt), 128'(m_rd));
        chk({tag, "_stat_to"}, 128'(stat_to_cnt), 128'(m_to));
`else
        chk({tag, "_no_rsp_pending"}, 128'(rsp_valid), '0);
`endif
    endtask

    //--------------------------------------------------------------------------
    // DDR3 IP model: drives ready/return signals at negedge, then checks any
    // command or write beat the bridge presents in that cycle.
    //--------------------------------------------------------------------------
    initial begin
        cmd_t c;
        cmd_ready = 1'b0; wr_data_rdy = 1'b0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
        rd_data = '0; rd_addr = '0;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                cmd_ready = 1'b0;
                stall_cnt--;
            end else begin
                cmd_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            wr_data_rdy   = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            rd_data_valid = 1'b0;
            rd_data_end   = 1'b0;
            rd_data       = {$urandom, $urandom, $urandom, $urandom};
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    rd_data_valid = 1'b1;
                    rd_data_end   = 1'b1;
                    rd_data       = ip_get(rd_addr);
                end
            end
            #1;
            if (!rst && cmd_en) begin
                n_cmd++;
                chk("cmd_ready_at_cmd_en", 128'(cmd_ready), 128'(1));
                chk("cmd_expected", 128'(cmd_q.size() != 0), 128'(1));
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    chk("cmd", 128'(cmd), 128'(c.we ? 3'd0 : 3'd1));
                    chk("app_addr", 128'(app_addr), 128'(c.addr));
                    if (c.we) begin
                        wpend = 1'b1;
                        wcur  = c;
                    end else begin
                        rd_addr = app_addr;
                        rd_cnt  = c.lat;
                    end
                end
            end
            if (!rst && (wr_data_en || wr_data_end)) begin
                chk("wr_data_end_eq_en", 128'(wr_data_end), 128'(wr_data_en));
                chk("wr_data_rdy_at_en", 128'(wr_data_rdy), 128'(1));
                chk("wr_expected", 128'(wpend), 128'(1));
                if (wpend) begin
                    chk("wr_data", wr_data, wcur.wdata);
                    chk("wr_data_mask", 128'(wr_data_mask), 128'(wcur.mask));
                    mem_ip[wcur.addr] = merge(ip_get(wcur.addr), wr_data, wr_data_mask);
                    wpend = 1'b0;
                end
            end
        end
    end

    // Response sink: rsp_ready random, or held low for a fixed number of
    // cycles once a response appears.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && bp_pending > 0) begin
                rsp_ready = 1'b0;
                bp_pending--;
            end else begin
                rsp_ready = rand_rsp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Response monitor
    //--------------------------------------------------------------------------
    initial begin
        rsp_t          e;
        logic [DW-1:0] h_rdata;
        logic          h_we, h_err;
        bit            hold, seen;
        hold = 1'b0; seen = 1'b0; h_rdata = '0; h_we = 1'b0; h_err = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
                seen = 1'b0;
            end else if (rsp_valid) begin
                chk("req_ready_low_in_resp", 128'(req_ready), '0);
                if (hold) begin
                    chk("rsp_rdata_stable", rsp_rdata, h_rdata);
                    chk("rsp_we_stable", 128'(rsp_we), 128'(h_we));
                    chk("rsp_err_stable", 128'(rsp_err), 128'(h_err));
                end
                if (!seen) begin
                    seen = 1'b1;
                    chk("rsp_expected", 128'(rsp_q.size() != 0), 128'(1));
                    if (rsp_q.size() != 0 && rsp_q[0].lat >= 0)
                        chk("rsp_latency", 128'(cyc - rsp_q[0].acc_cyc), 128'(rsp_q[0].lat));
                end
                if (rsp_ready) begin
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_we", 128'(rsp_we), 128'(e.we));
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 128'(rsp_err), 128'(e.err));
                        if (e.we) m_wr++; else m_rd++;
                        if (e.err && m_to != 65535) m_to++;
                    end
                    hold = 1'b0;
                    seen = 1'b0;
                end else begin
                    hold    = 1'b1;
                    h_rdata = rsp_rdata;
                    h_we    = rsp_we;
                    h_err   = rsp_err;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

    //--------------------------------------------------------------------------
    // Test sequence
    //--------------------------------------------------------------------------
    localparam logic [DW-1:0] c_WDATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [DW-1:0] c_A5    = {16{8'hA5}};

    initial begin
        int n0;
        logic [AW-1:0] addrs [8];
        rst = 1'b1; init_calib_complete = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        for (int i = 0; i < 8; i++) addrs[i] = AW'(32'h0000_0100 + i * 32'h40);

        repeat (3) @(negedge clk);
        #1 chk_zero_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Calibration gating with a request waiting
        req_valid = 1'b1; req_we = 1'b1; req_addr = 27'h0000100;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            chk("gate_req_ready", 128'(req_ready), '0);
            chk("gate_cmd_en", 128'(cmd_en), '0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        init_calib_complete = 1'b1;
        @(negedge clk); #1;
        chk("calib_req_ready", 128'(req_ready), 128'(1));

        // Directed write, all ready: 3-cycle latency
        send(1'b1, 27'h0001234, c_WDATA, 16'h0000, 0, 3);
        drain("drain_write");
        // Preload A5 pattern with a partially masked write over an existing line
        send(1'b1, 27'h0000200, c_A5, 16'h0000, 0, 3);
        send(1'b1, 27'h0000200, c_WDATA, 16'hFFF0, 0, 3);
        drain("drain_preload");

        // Read with command stall
        stall_cnt = 7;
        send(1'b0, 27'h0000200, '0, '0, 14, -1);
        drain("drain_stall_read");
        send(1'b0, 27'h0001234, '0, '0, 1, 3);
        // Valid in the last allowed cycle wins over the timeout
        send(1'b0, 27'h0001234, '0, '0, TO, TO + 2);
        drain("drain_reads");

        // Timeout, no return; then a return landing in RESP and one in IDLE
        send(1'b0, 27'h0000200, '0, '0, 0, TO + 2);
        drain("drain_timeout");
        chk_stats("after_timeout");
        send(1'b0, 27'h0000200, '0, '0, TO + 1, TO + 2);
        send(1'b0, 27'h0000200, '0, '0, TO + 2, TO + 2);
        drain("drain_late");
        repeat (4) @(negedge clk);

        // Response backpressure
        bp_pending = 10;
        send(1'b0, 27'h0000200, '0, '0, 3, 5);
        drain("drain_bp");

        // Back-to-back 4 writes then 4 reads
        n0 = n_cmd;
        for (int i = 0; i < 4; i++)
            send(1'b1, addrs[i], {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 0, -1);
        for (int i = 0; i < 4; i++)
            send(1'b0, addrs[i], '0, '0, 2 + i, -1);
        drain("drain_b2b");
        chk("b2b_cmd_en_pulses", 128'(n_cmd - n0), 128'(8));
        chk_stats("after_b2b");

        // Reset while waiting for read data
        send(1'b0, addrs[0], '0, '0, 0, -1);
        repeat (5) @(negedge clk);
        #3 rst = 1'b1;
        init_calib_complete = 1'b0;
        #1 chk_zero_outputs("rst_rwait");
        cmd_q.delete(); rsp_q.delete(); rd_cnt = 0; wpend = 1'b0;
        m_wr = 0; m_rd = 0; m_to = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("post_rst_waits_calib", 128'(req_ready), '0);
        chk_stats("post_rst");
        @(negedge clk) init_calib_complete = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_calib_ready", 128'(req_ready), 128'(1));

        // Random traffic
        rand_rdy = 1'b1;
        rand_rsp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int r, lat;
            logic we;
            if (i == 40) init_calib_complete = 1'b0;  // must be ignored
            if (i == 70) init_calib_complete = 1'b1;
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 19);
            lat = (r < 16) ? r + 1 : (r == 16) ? 0 : (r == 17) ? TO + 1 : (r == 18) ? TO + 2 : TO;
            send(we, addrs[$urandom_range(0, 7)], {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000, lat, -1);
        end
        drain("drain_random");
        rand_rsp = 1'b0;
        repeat (4) @(negedge clk);
        #1 chk_stats("final");
        chk("total_cmd_en", 128'(n_cmd), 128'(n_req));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
